// File: rtl/ahb_subordinate_protocol_if.sv
// AHB-Lite bus plus peripheral request signalling for one subordinate slot.
interface ahb_subordinate_protocol_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   // AHB manager side
   logic                    HSEL;
   logic [ADDR_WIDTH-1:0]   HADDR;
   logic [1:0]              HTRANS;
   logic [2:0]              HSIZE;
   logic                    HWRITE;
   logic [2:0]              HBURST;
   logic [DATA_WIDTH-1:0]   HWDATA;
   logic                    HREADY;
   logic                    HREADYOUT;
   logic                    HRESP;
   logic [DATA_WIDTH-1:0]   HRDATA;

   // Peripheral protocol side
   logic                    wen;
   logic                    ren;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] strobe;
   logic                    is_burst;
   logic [1:0]              burst_type;
   logic [7:0]              burst_length;
   logic                    secure_transfer;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    error;
   logic                    request_stall;

   // Subordinate (this block) view
   modport slave (
      input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HBURST, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA,
      output wen, ren, addr, wdata, strobe, is_burst, burst_type, burst_length, secure_transfer,
      input  rdata, error, request_stall
   );

   // Environment view: AHB manager plus peripheral
   modport master (
      output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HBURST, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA,
      input  wen, ren, addr, wdata, strobe, is_burst, burst_type, burst_length, secure_transfer,
      output rdata, error, request_stall
   );
endinterface

// File: rtl/ahb_subordinate_protocol.sv
// AHB-Lite subordinate front end: turns address/data-phase transfers into
// wen/ren peripheral requests with stall and two-cycle error responses.
module ahb_subordinate_protocol #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic                       CLK,
   input logic                       nRST,
   ahb_subordinate_protocol_if.slave bus
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   // Only a 32-bit data path is supported
   generate
      if (DATA_WIDTH != 32) begin : g_bad_width
         $error("ahb_subordinate_protocol: DATA_WIDTH must be 32");
      end
   endgenerate

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERR1, ST_ERR2} state_e;

   state_e                  state_q, state_d;
   logic                    write_q, write_d;
   logic                    wen_q, wen_d;
   logic                    ren_q, ren_d;
   logic                    hresp_q, hresp_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [STRB_WIDTH-1:0]   strobe_q, strobe_d;
   logic                    is_burst_q, is_burst_d;
   logic [1:0]              burst_type_q, burst_type_d;
   logic [7:0]              burst_length_q, burst_length_d;

   logic                    accept;
   logic                    illegal;
   logic                    take;
   logic                    hready_c;
   logic [STRB_WIDTH-1:0]   strobe_calc;
   logic [7:0]              burst_length_calc;

   // Address-phase qualification
   always_comb accept = bus.HSEL && bus.HREADY && bus.HTRANS[1];

   // Byte lanes and alignment legality of the address-phase transfer
   always_comb begin
      illegal     = 1'b0;
      strobe_calc = '0;
      case (bus.HSIZE)
         3'd0: strobe_calc = STRB_WIDTH'(4'b0001 << bus.HADDR[1:0]);
         3'd1: begin
            strobe_calc = STRB_WIDTH'(4'b0011 << {bus.HADDR[1], 1'b0});
            illegal     = bus.HADDR[0];
         end
         3'd2: begin
            strobe_calc = STRB_WIDTH'(4'b1111);
            illegal     = (bus.HADDR[1:0] != 2'b00);
         end
         default: illegal = 1'b1;
      endcase
   end

   // Burst length hint decoded from HBURST
   always_comb begin
      burst_length_calc = 8'd16;
      case (bus.HBURST)
         3'd0:       burst_length_calc = 8'd1;
         3'd1:       burst_length_calc = 8'd0;
         3'd2, 3'd3: burst_length_calc = 8'd4;
         3'd4, 3'd5: burst_length_calc = 8'd8;
         default:    burst_length_calc = 8'd16;
      endcase
   end

   // Next state, captured transfer attributes and ready generation
   always_comb begin
      state_d        = state_q;
      write_d        = write_q;
      addr_d         = addr_q;
      strobe_d       = strobe_q;
      is_burst_d     = is_burst_q;
      burst_type_d   = burst_type_q;
      burst_length_d = burst_length_q;
      take           = 1'b0;
      hready_c       = 1'b1;

      case (state_q)
         ST_IDLE, ST_ERR2: begin
            state_d = ST_IDLE;
            take    = accept;
         end
         ST_ACCESS: begin
            if (bus.request_stall) begin
               hready_c = 1'b0;
            end else if (bus.error) begin
               // Data phase ends in an error: hold the manager until ERR2
               hready_c = 1'b0;
               state_d  = ST_ERR1;
            end else begin
               state_d = ST_IDLE;
               take    = accept;
            end
         end
         ST_ERR1: begin
            hready_c = 1'b0;
            state_d  = ST_ERR2;
         end
         default: state_d = ST_IDLE;
      endcase

      if (take) begin
         state_d        = illegal ? ST_ERR1 : ST_ACCESS;
         write_d        = bus.HWRITE;
         addr_d         = bus.HADDR;
         strobe_d       = strobe_calc;
         is_burst_d     = (bus.HBURST != 3'd0);
         burst_type_d   = {1'b0, bus.HBURST[0]};
         burst_length_d = burst_length_calc;
      end

      wen_d   = (state_d == ST_ACCESS) && write_d;
      ren_d   = (state_d == ST_ACCESS) && !write_d;
      hresp_d = (state_d == ST_ERR1) || (state_d == ST_ERR2);
   end

   // State and output registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q        <= ST_IDLE;
         write_q        <= 1'b0;
         wen_q          <= 1'b0;
         ren_q          <= 1'b0;
         hresp_q        <= 1'b0;
         addr_q         <= '0;
         strobe_q       <= '0;
         is_burst_q     <= 1'b0;
         burst_type_q   <= 2'd0;
         burst_length_q <= 8'd0;
      end else begin
         state_q        <= state_d;
         write_q        <= write_d;
         wen_q          <= wen_d;
         ren_q          <= ren_d;
         hresp_q        <= hresp_d;
         addr_q         <= addr_d;
         strobe_q       <= strobe_d;
         is_burst_q     <= is_burst_d;
         burst_type_q   <= burst_type_d;
         burst_length_q <= burst_length_d;
      end
   end

   assign bus.HREADYOUT       = hready_c;
   assign bus.HRESP           = hresp_q;
   assign bus.HRDATA          = ((state_q == ST_ACCESS) && ren_q) ? bus.rdata : '0;
   assign bus.wen             = wen_q;
   assign bus.ren             = ren_q;
   assign bus.addr            = addr_q;
   assign bus.wdata           = bus.HWDATA;
   assign bus.strobe          = strobe_q;
   assign bus.is_burst        = is_burst_q;
   assign bus.burst_type      = burst_type_q;
   assign bus.burst_length    = burst_length_q;
   assign bus.secure_transfer = 1'b0;
endmodule
